// File: rtl/regression_sequencer_if.sv
// Handshake bundle between the regression sequencer, top-level control and the stage instances.
interface regression_sequencer_if;
  logic       go;
  logic       data_ready;
  logic       input_error;
  logic       start_transpose;
  logic       done_transpose;
  logic       start_mul_xtx;
  logic       done_mul_xtx;
  logic       start_mul_xty;
  logic       done_mul_xty;
  logic       start_inverse;
  logic       done_inverse;
  logic       invalid;
  logic       start_final;
  logic       done_final;
  logic       busy;
  logic       result_valid;
  logic       err_det;
  logic       err_input;
  logic       err_timeout;
  logic [2:0] state_dbg;

  modport master (
    output go, data_ready, input_error,
    output done_transpose, done_mul_xtx, done_mul_xty, done_inverse, invalid, done_final,
    input  start_transpose, start_mul_xtx, start_mul_xty, start_inverse, start_final,
    input  busy, result_valid, err_det, err_input, err_timeout, state_dbg
  );

  modport slave (
    input  go, data_ready, input_error,
    input  done_transpose, done_mul_xtx, done_mul_xty, done_inverse, invalid, done_final,
    output start_transpose, start_mul_xtx, start_mul_xty, start_inverse, start_final,
    output busy, result_valid, err_det, err_input, err_timeout, state_dbg
  );
endinterface

// File: rtl/regression_sequencer.sv
// Control FSM for the least-squares regression datapath: launches each stage in dependency
// order, waits for its done, and traps singular matrices, input errors and stalled stages.
module regression_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  regression_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRANSPOSE = 3'd1,
    MUL       = 3'd2,
    INV       = 3'd3,
    FINAL     = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_t;

  state_t               state_q, state_n;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_n;
  logic                 xtx_seen_q, xtx_seen_n;
  logic                 xty_seen_q, xty_seen_n;
  logic                 start_tr_q, start_tr_n;
  logic                 start_mul_q, start_mul_n;
  logic                 start_inv_q, start_inv_n;
  logic                 start_fin_q, start_fin_n;
  logic                 busy_q, busy_n;
  logic                 rv_q, rv_n;
  logic                 err_det_q, err_det_n;
  logic                 err_input_q, err_input_n;
  logic                 err_timeout_q, err_timeout_n;
  logic                 timeout_c;
  logic                 in_stage_c;
  logic                 entry_c;

  // State, counter, sticky done flags and every output are flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      xtx_seen_q    <= 1'b0;
      xty_seen_q    <= 1'b0;
      start_tr_q    <= 1'b0;
      start_mul_q   <= 1'b0;
      start_inv_q   <= 1'b0;
      start_fin_q   <= 1'b0;
      busy_q        <= 1'b0;
      rv_q          <= 1'b0;
      err_det_q     <= 1'b0;
      err_input_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      xtx_seen_q    <= xtx_seen_n;
      xty_seen_q    <= xty_seen_n;
      start_tr_q    <= start_tr_n;
      start_mul_q   <= start_mul_n;
      start_inv_q   <= start_inv_n;
      start_fin_q   <= start_fin_n;
      busy_q        <= busy_n;
      rv_q          <= rv_n;
      err_det_q     <= err_det_n;
      err_input_q   <= err_input_n;
      err_timeout_q <= err_timeout_n;
    end
  end

  // Next state; outputs are derived from the next state so pulses land in a state's first cycle.
  always_comb begin
    state_n       = state_q;
    xtx_seen_n    = xtx_seen_q;
    xty_seen_n    = xty_seen_q;
    rv_n          = rv_q;
    err_det_n     = err_det_q;
    err_input_n   = err_input_q;
    err_timeout_n = err_timeout_q;
    timeout_c     = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (bus.go && (bus.input_error || bus.data_ready)) begin
          rv_n          = 1'b0;
          err_det_n     = 1'b0;
          err_timeout_n = 1'b0;
          err_input_n   = bus.input_error;
          state_n       = bus.input_error ? ERROR : TRANSPOSE;
        end
      end
      TRANSPOSE: begin
        if (bus.done_transpose) begin
          state_n = MUL;
        end else if (timeout_c) begin
          state_n       = ERROR;
          err_timeout_n = 1'b1;
        end
      end
      MUL: begin
        xtx_seen_n = xtx_seen_q | bus.done_mul_xtx;
        xty_seen_n = xty_seen_q | bus.done_mul_xty;
        if (xtx_seen_n && xty_seen_n) begin
          state_n = INV;
        end else if (timeout_c) begin
          state_n       = ERROR;
          err_timeout_n = 1'b1;
        end
        if (state_n != MUL) begin
          xtx_seen_n = 1'b0;
          xty_seen_n = 1'b0;
        end
      end
      INV: begin
        if (bus.done_inverse) begin
          state_n   = bus.invalid ? ERROR : FINAL;
          err_det_n = bus.invalid;
        end else if (timeout_c) begin
          state_n       = ERROR;
          err_timeout_n = 1'b1;
        end
      end
      FINAL: begin
        if (bus.done_final) begin
          state_n = DONE;
          rv_n    = 1'b1;
        end else if (timeout_c) begin
          state_n       = ERROR;
          err_timeout_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    in_stage_c  = (state_q == TRANSPOSE) || (state_q == MUL) ||
                  (state_q == INV) || (state_q == FINAL);
    entry_c     = (state_n != state_q);
    cnt_n       = (entry_c || !in_stage_c) ? '0 : cnt_q + CNT_WIDTH'(1);
    start_tr_n  = entry_c && (state_n == TRANSPOSE);
    start_mul_n = entry_c && (state_n == MUL);
    start_inv_n = entry_c && (state_n == INV);
    start_fin_n = entry_c && (state_n == FINAL);
    busy_n      = (state_n == TRANSPOSE) || (state_n == MUL) ||
                  (state_n == INV) || (state_n == FINAL);
  end

  assign bus.start_transpose = start_tr_q;
  assign bus.start_mul_xtx   = start_mul_q;
  assign bus.start_mul_xty   = start_mul_q;
  assign bus.start_inverse   = start_inv_q;
  assign bus.start_final     = start_fin_q;
  assign bus.busy            = busy_q;
  assign bus.result_valid    = rv_q;
  assign bus.err_det         = err_det_q;
  assign bus.err_input       = err_input_q;
  assign bus.err_timeout     = err_timeout_q;
  assign bus.state_dbg       = state_q;

endmodule

// File: tb/tb_regression_sequencer.sv
// Scoreboard bench for regression_sequencer: directed runs push expected pulse/flag events,
// a negedge monitor pops and compares them against what the sequencer actually emits.
module tb_regression_sequencer;

  localparam int EV_TR   = 1;
  localparam int EV_XTX  = 2;
  localparam int EV_XTY  = 3;
  localparam int EV_INV  = 4;
  localparam int EV_FIN  = 5;
  localparam int EV_RV   = 6;
  localparam int EV_EDET = 7;
  localparam int EV_EIN  = 8;
  localparam int EV_ETO  = 9;

  typedef struct {
    int kind;
    int rel;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   base;
  int   checks;
  int   errors;
  ev_t  exp_q[$];

  // Stage stub response delays (0 = never respond) and countdowns.
  int d_tr, d_xtx, d_xty, d_inv, d_fin;
  int c_tr, c_xtx, c_xty, c_inv, c_fin;
  bit inv_mode;

  logic prv_rv, prv_ed, prv_ei, prv_et;

  regression_sequencer_if bus ();

  regression_sequencer #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int rel);
    ev_t e;
    e.kind = kind;
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  task automatic push_nominal();
    push(EV_TR, 1); push(EV_XTX, 3); push(EV_XTY, 3);
    push(EV_INV, 5); push(EV_FIN, 7); push(EV_RV, 9);
  endtask

  task automatic set_delays(input int tr, input int xtx, input int xty, input int inv, input int fin);
    d_tr = tr; d_xtx = xtx; d_xty = xty; d_inv = inv; d_fin = fin;
  endtask

  function automatic int all_outputs();
    return int'({bus.start_transpose, bus.start_mul_xtx, bus.start_mul_xty, bus.start_inverse,
                 bus.start_final, bus.busy, bus.result_valid, bus.err_det, bus.err_input,
                 bus.err_timeout, bus.state_dbg});
  endfunction

  // Ends at the negedge of the cycle rel cycles after the launch cycle.
  task automatic wait_rel(input int r);
    do @(negedge clk); while (cyc - base < r);
  endtask

  // Pulses go for one cycle; cycle 0 is the cycle in which go is sampled.
  task automatic launch();
    @(posedge clk); #1;
    base   = cyc;
    bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
  endtask

  // Stage stubs: capture a start at negedge, raise done 'delay' cycles later.
  initial begin
    bus.done_transpose = 1'b0; bus.done_mul_xtx = 1'b0; bus.done_mul_xty = 1'b0;
    bus.done_inverse   = 1'b0; bus.done_final   = 1'b0; bus.invalid      = 1'b0;
    c_tr = 0; c_xtx = 0; c_xty = 0; c_inv = 0; c_fin = 0;
    forever begin
      @(negedge clk);
      if (bus.start_transpose) c_tr  = d_tr;
      if (bus.start_mul_xtx)   c_xtx = d_xtx;
      if (bus.start_mul_xty)   c_xty = d_xty;
      if (bus.start_inverse)   c_inv = d_inv;
      if (bus.start_final)     c_fin = d_fin;
      @(posedge clk); #1;
      bus.done_transpose = (c_tr  == 1);
      bus.done_mul_xtx   = (c_xtx == 1);
      bus.done_mul_xty   = (c_xty == 1);
      bus.done_inverse   = (c_inv == 1);
      bus.done_final     = (c_fin == 1);
      bus.invalid        = bus.done_inverse & inv_mode;
      if (c_tr  > 0) c_tr--;
      if (c_xtx > 0) c_xtx--;
      if (c_xty > 0) c_xty--;
      if (c_inv > 0) c_inv--;
      if (c_fin > 0) c_fin--;
    end
  end

  // Monitor: every start level and every flag rising edge is an event matched against the queue.
  always @(negedge clk) begin
    logic [9:1] ev;
    ev_t e;
    ev = {bus.err_timeout & ~prv_et, bus.err_input & ~prv_ei, bus.err_det & ~prv_ed,
          bus.result_valid & ~prv_rv, bus.start_final, bus.start_inverse,
          bus.start_mul_xty, bus.start_mul_xtx, bus.start_transpose};
    if (!rst) begin
      for (int k = 1; k <= 9; k++) begin
        if (ev[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d at rel %0d, expected none", k, cyc - base);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.rel != cyc - base) begin
              errors++;
              $display("FAIL event: got kind %0d at rel %0d, expected kind %0d at rel %0d",
                       k, cyc - base, e.kind, e.rel);
            end
          end
        end
      end
    end
    prv_rv = bus.result_valid;
    prv_ed = bus.err_det;
    prv_ei = bus.err_input;
    prv_et = bus.err_timeout;
  end

  initial begin
    checks = 0; errors = 0; base = 0; inv_mode = 1'b0;
    prv_rv = 1'b0; prv_ed = 1'b0; prv_ei = 1'b0; prv_et = 1'b0;
    set_delays(1, 1, 1, 1, 1);
    bus.go = 1'b0; bus.data_ready = 1'b0; bus.input_error = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", all_outputs(), 0);
    @(posedge clk); #3;
    rst = 1'b0;

    // go without data_ready: stays IDLE
    launch();
    wait_rel(4);
    chk("nodata_state", int'(bus.state_dbg), 0);
    chk("nodata_busy", int'(bus.busy), 0);

    // nominal run with busy profile
    bus.data_ready = 1'b1;
    push_nominal();
    launch();
    for (int r = 1; r <= 10; r++) begin
      wait_rel(r);
      chk($sformatf("nominal_busy_c%0d", r), int'(bus.busy), (r >= 1 && r <= 8) ? 1 : 0);
    end
    chk("nominal_state", int'(bus.state_dbg), 5);
    chk("nominal_rv", int'(bus.result_valid), 1);

    // input error at launch
    bus.input_error = 1'b1;
    push(EV_EIN, 1);
    launch();
    bus.input_error = 1'b0;
    wait_rel(1);
    chk("inerr_state", int'(bus.state_dbg), 6);
    chk("inerr_rv_cleared", int'(bus.result_valid), 0);
    wait_rel(3);

    // go pulsed during MUL is ignored
    push_nominal();
    launch();
    wait_rel(2);
    @(posedge clk); #1;
    bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    wait_rel(11);
    chk("gomul_state", int'(bus.state_dbg), 5);
    chk("gomul_err_input_cleared", int'(bus.err_input), 0);

    // skewed multiplies, both orders
    for (int s = 0; s < 2; s++) begin
      if (s == 0) set_delays(1, 1, 4, 1, 1);
      else        set_delays(1, 4, 1, 1, 1);
      push(EV_TR, 1); push(EV_XTX, 3); push(EV_XTY, 3);
      push(EV_INV, 8); push(EV_FIN, 10); push(EV_RV, 12);
      launch();
      wait_rel(14);
      chk($sformatf("skew%0d_state", s), int'(bus.state_dbg), 5);
    end
    set_delays(1, 1, 1, 1, 1);

    // singular matrix, then recovery
    inv_mode = 1'b1;
    push(EV_TR, 1); push(EV_XTX, 3); push(EV_XTY, 3); push(EV_INV, 5); push(EV_EDET, 7);
    launch();
    wait_rel(10);
    chk("singular_state", int'(bus.state_dbg), 6);
    chk("singular_err_det", int'(bus.err_det), 1);
    chk("singular_rv", int'(bus.result_valid), 0);
    inv_mode = 1'b0;
    push_nominal();
    launch();
    wait_rel(11);
    chk("recover_err_det", int'(bus.err_det), 0);
    chk("recover_state", int'(bus.state_dbg), 5);

    // stalled transpose times out 16 cycles after entry
    set_delays(0, 1, 1, 1, 1);
    push(EV_TR, 1); push(EV_ETO, 17);
    launch();
    wait_rel(16);
    chk("timeout_pre_state", int'(bus.state_dbg), 1);
    wait_rel(17);
    chk("timeout_state", int'(bus.state_dbg), 6);
    chk("timeout_flag", int'(bus.err_timeout), 1);
    wait_rel(19);

    // done on the last allowed cycle wins over timeout
    set_delays(15, 1, 1, 1, 1);
    push(EV_TR, 1); push(EV_XTX, 17); push(EV_XTY, 17);
    push(EV_INV, 19); push(EV_FIN, 21); push(EV_RV, 23);
    launch();
    wait_rel(17);
    chk("lastcycle_state", int'(bus.state_dbg), 2);
    chk("lastcycle_err_timeout", int'(bus.err_timeout), 0);
    wait_rel(25);
    chk("lastcycle_final_state", int'(bus.state_dbg), 5);
    set_delays(1, 1, 1, 1, 1);

    // asynchronous reset while in INV
    push(EV_TR, 1); push(EV_XTX, 3); push(EV_XTY, 3);
    launch();
    wait_rel(4);
    @(posedge clk); #1;
    chk("pre_reset_state", int'(bus.state_dbg), 3);
    #1;
    rst = 1'b1;
    #1;
    chk("midrun_reset_outputs", all_outputs(), 0);
    repeat (2) @(posedge clk); #3;
    rst = 1'b0;
    push_nominal();
    launch();
    wait_rel(11);
    chk("post_reset_state", int'(bus.state_dbg), 5);
    chk("post_reset_rv", int'(bus.result_valid), 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
